// File: rtl/rsa_pkg.sv
// Shared constants and state encoding for the RSA Montgomery front-end helpers.
package rsa_pkg;

  localparam int RSA_WIDTH = 2048;
  localparam int RSA_LEN_W = 11;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } n_len_state_t;

endpackage

// File: rtl/mont_n_len.sv
// Finds the index of the most-significant set bit of modulus n by shifting it
// left until the top bit is set, counting down from WIDTH-1; sticky finish.
module mont_n_len
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int LEN_W = RSA_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] n,
  output logic [LEN_W-1:0] n_len,
  output logic             finish
);

  n_len_state_t     state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [LEN_W-1:0] counter_q, counter_d;
  logic [LEN_W-1:0] n_len_q, n_len_d;
  logic             finish_q, finish_d;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    counter_d = counter_q;
    n_len_d   = n_len_q;
    finish_d  = finish_q;
    case (state_q)
      LOAD: begin
        sreg_d    = n;
        counter_d = LEN_W'(WIDTH - 1);
        state_d   = SCAN;
      end
      SCAN: begin
        if (sreg_q[WIDTH-1]) begin
          n_len_d  = counter_q;
          finish_d = 1'b1;
          state_d  = DONE;
        end else if (counter_q == '0) begin
          // n == 0: report 0, indistinguishable from n == 1 by design
          n_len_d  = '0;
          finish_d = 1'b1;
          state_d  = DONE;
        end else begin
          sreg_d    = sreg_q << 1;
          counter_d = counter_q - 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      sreg_q    <= '0;
      counter_q <= '0;
      n_len_q   <= '0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      counter_q <= counter_d;
      n_len_q   <= n_len_d;
      finish_q  <= finish_d;
    end
  end

  assign n_len  = n_len_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_mont_n_len.sv
// Self-checking bench for mont_n_len: table vectors, random moduli against a
// bit-scan reference model, and reset corner sequences.
module tb_mont_n_len;
  import rsa_pkg::*;

  localparam int W   = RSA_WIDTH;
  localparam int LW  = RSA_LEN_W;
  localparam int MAX_EDGES = 2200;

  logic          clk;
  logic          rst;
  logic [W-1:0]  n;
  logic [LW-1:0] n_len;
  logic          finish;

  int vectors;
  int miscompares;

  mont_n_len dut (
    .clk    (clk),
    .rst    (rst),
    .n      (n),
    .n_len  (n_len),
    .finish (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] nv;
    int           exp_len;
    int           exp_lat;
    bit           toggle;
  } vec_t;

  // Reference: highest set bit by plain scan, -1 for zero.
  function automatic int ref_msb(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic int ref_len(input logic [W-1:0] v);
    int k;
    k = ref_msb(v);
    return (k < 0) ? 0 : k;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] v);
    int k;
    k = ref_msb(v);
    return (k < 0) ? (W + 1) : (2 + (W - 1 - k));
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits from a just-released reset until finish, checking that finish and
  // n_len stay low before the expected edge. Inputs are driven at negedge.
  task automatic wait_finish(input string tag, input int exp_len, input int exp_lat,
                             input bit toggle);
    int  lat;
    bit  early_bad;
    lat = -1;
    early_bad = 1'b0;
    for (int e = 1; e <= MAX_EDGES; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (toggle && e == 1) n = '1;
      if (finish) begin
        lat = e;
        break;
      end
      if (n_len != '0) early_bad = 1'b1;
    end
    check({tag, " no_early_nlen"}, int'(early_bad), 0);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " n_len"}, int'(n_len), exp_len);
    $display("%s: n_len=%0d latency=%0d (expect %0d/%0d)", tag, n_len, lat, exp_len, exp_lat);
  endtask

  task automatic apply_reset(input logic [W-1:0] nv);
    @(negedge clk);
    rst = 1'b1;
    n   = nv;
    @(posedge clk);
    @(negedge clk);
    check("reset finish", int'(finish), 0);
    check("reset n_len", int'(n_len), 0);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    apply_reset(v.nv);
    wait_finish(v.name, v.exp_len, v.exp_lat, v.toggle);
  endtask

  vec_t         tbl[6];
  logic [W-1:0] one;
  logic [W-1:0] tmp;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    n           = '0;
    one         = 1;

    tmp = rand_wide();
    tmp[W-1 -: 16] = 16'h81c8;
    tmp[15:0]      = 16'h1a93;
    tbl[0] = '{"top_bit",   tmp,                         W - 1, 2,     1'b0};
    tbl[1] = '{"bit1000",   one << 1000,                 1000,  1049,  1'b0};
    tbl[2] = '{"one",       one,                         0,     W + 1, 1'b0};
    tbl[3] = '{"zero",      '0,                          0,     W + 1, 1'b0};
    tbl[4] = '{"b5b3",      (one << 5) | (one << 3),     5,     2044,  1'b0};
    tbl[5] = '{"b5b3_togl", (one << 5) | (one << 3),     5,     2044,  1'b1};

    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      run_vec(tbl[i]);
      if (i == 0) begin
        // Result must hold for several cycles afterwards.
        #50;
        @(negedge clk);
        check("top_bit hold finish", int'(finish), 1);
        check("top_bit hold n_len", int'(n_len), W - 1);
      end
    end

    // Random moduli against the reference model.
    for (int r = 0; r < 8; r++) begin
      vec_t v;
      int   k;
      k    = (r < 4) ? $urandom_range(1500, W - 1) : $urandom_range(0, W - 1);
      tmp  = rand_wide() & ((one << k) - 1);
      tmp  = tmp | (one << k);
      v.name    = $sformatf("rand%0d_k%0d", r, k);
      v.nv      = tmp;
      v.exp_len = ref_len(tmp);
      v.exp_lat = ref_lat(tmp);
      v.toggle  = 1'b0;
      run_vec(v);
    end

    // Reset mid-scan at edge 500, with n changed before release.
    @(negedge clk);
    rst = 1'b1;
    n   = one << 10;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e < 500; e++) begin
      @(posedge clk);
    end
    @(negedge clk);
    check("midscan pre finish", int'(finish), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midscan rst finish", int'(finish), 0);
    check("midscan rst n_len", int'(n_len), 0);
    n   = one << (W - 1);
    rst = 1'b0;
    wait_finish("midscan_restart", W - 1, 2, 1'b0);

    // Reset while in DONE: same n must give same result and latency.
    tmp = (one << 700) | (one << 3);
    apply_reset(tmp);
    wait_finish("done_first", ref_len(tmp), ref_lat(tmp), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("done rst finish", int'(finish), 0);
    check("done rst n_len", int'(n_len), 0);
    rst = 1'b0;
    wait_finish("done_repeat", ref_len(tmp), ref_lat(tmp), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
